// File: rtl/instr_pkg.sv
// Shared opcodes, command kinds, immediate field ranges and FSM state type
// for the instruction encoder/sequencer.
package instr_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_PADDSB = 4'h1;
  localparam logic [3:0] OP_SUB    = 4'h2;
  localparam logic [3:0] OP_XOR    = 4'h3;
  localparam logic [3:0] OP_RED    = 4'h4;
  localparam logic [3:0] OP_SLL    = 4'h5;
  localparam logic [3:0] OP_SRA    = 4'h6;
  localparam logic [3:0] OP_ROR    = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LHB    = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_JAL    = 4'hD;
  localparam logic [3:0] OP_JR     = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [4:0] KIND_LI  = 5'd16;
  localparam logic [4:0] KIND_MOV = 5'd17;

  localparam int SHIFT_MIN = 0;
  localparam int SHIFT_MAX = 15;
  localparam int LWSW_MIN  = -8;
  localparam int LWSW_MAX  = 7;
  localparam int IMM8_MIN  = -128;
  localparam int IMM8_MAX  = 255;
  localparam int BR_MIN    = -256;
  localparam int BR_MAX    = 255;
  localparam int JAL_MIN   = -2048;
  localparam int JAL_MAX   = 2047;

  typedef enum logic [1:0] {IDLE, OUT, OUT_HI} state_e;

  function automatic logic out_of_range(input int v, input int lo, input int hi);
    return (v < lo) || (v > hi);
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational field packer: turns one command into one or two 16-bit
// instruction words and flags commands that must be dropped.
module instr_field_pack
  import instr_pkg::*;
#(
  parameter int RANGE_CHK = 1,
  parameter int LI_SHORT  = 1
) (
  input  logic [4:0]  kind_i,
  input  logic [3:0]  rd_i,
  input  logic [3:0]  rs_i,
  input  logic [3:0]  rt_i,
  input  logic [15:0] imm_i,
  output logic [15:0] word0_o,
  output logic [15:0] word1_o,
  output logic        two_words_o,
  output logic        range_err_o
);

  logic oor;
  logic illegal;
  int   imm_v;

  // NOTE: every output of this block is given a default first, so no path
  // through the case statements can leave a value unassigned and infer a latch.
  always_comb begin
    word0_o     = 16'h0000;
    word1_o     = 16'h0000;
    two_words_o = 1'b0;
    oor         = 1'b0;
    illegal     = 1'b0;
    imm_v       = int'($signed(imm_i));

    if (!kind_i[4]) begin
      case (kind_i[3:0])
        OP_ADD, OP_PADDSB, OP_SUB, OP_XOR, OP_RED:
          word0_o = {kind_i[3:0], rd_i, rs_i, rt_i};
        OP_SLL, OP_SRA, OP_ROR: begin
          word0_o = {kind_i[3:0], rd_i, rs_i, imm_i[3:0]};
          oor     = out_of_range(imm_v, SHIFT_MIN, SHIFT_MAX);
        end
        OP_LW, OP_SW: begin
          word0_o = {kind_i[3:0], rd_i, rs_i, imm_i[3:0]};
          oor     = out_of_range(imm_v, LWSW_MIN, LWSW_MAX);
        end
        OP_LHB, OP_LLB: begin
          word0_o = {kind_i[3:0], rd_i, imm_i[7:0]};
          oor     = out_of_range(imm_v, IMM8_MIN, IMM8_MAX);
        end
        OP_B: begin
          // rd[2:0] carries the branch condition
          word0_o = {OP_B, rd_i[2:0], imm_i[8:0]};
          oor     = out_of_range(imm_v, BR_MIN, BR_MAX);
        end
        OP_JAL: begin
          word0_o = {OP_JAL, imm_i[11:0]};
          oor     = out_of_range(imm_v, JAL_MIN, JAL_MAX);
        end
        OP_JR:   word0_o = {OP_JR, 4'h0, rs_i, 4'h0};
        default: word0_o = {OP_HLT, 12'h000};
      endcase
    end else begin
      case (kind_i)
        KIND_LI: begin
          word0_o     = {OP_LLB, rd_i, imm_i[7:0]};
          word1_o     = {OP_LHB, rd_i, imm_i[15:8]};
          two_words_o = !((LI_SHORT != 0) && (imm_i == {{8{imm_i[7]}}, imm_i[7:0]}));
        end
        KIND_MOV: word0_o = {OP_ADD, rd_i, rs_i, 4'h0};
        default:  illegal = 1'b1;
      endcase
    end

    range_err_o = illegal || ((RANGE_CHK != 0) && oor);
  end

endmodule

// File: rtl/instr_seq_enc.sv
// Instruction encoder/sequencer: command stream in, packed instruction words out.
// Define INSTR_SEQ_ENC_SKID_EN for a 2-entry output skid with registered cmd_ready.
module instr_seq_enc
  import instr_pkg::*;
#(
  parameter int RANGE_CHK = 1,
  parameter int LI_SHORT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_kind,
  input  logic [3:0]  cmd_rd,
  input  logic [3:0]  cmd_rs,
  input  logic [3:0]  cmd_rt,
  input  logic [15:0] cmd_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic        out_last,
  output logic        err_range
);

  logic [15:0] word0, word1;
  logic        two_words, range_err;
  logic        accept;
  logic        err_q, err_d;
  logic [15:0] hi_q, hi_d;
  state_e      state_q, state_d;

  instr_field_pack #(
    .RANGE_CHK(RANGE_CHK),
    .LI_SHORT (LI_SHORT)
  ) u_pack (
    .kind_i     (cmd_kind),
    .rd_i       (cmd_rd),
    .rs_i       (cmd_rs),
    .rt_i       (cmd_rt),
    .imm_i      (cmd_imm),
    .word0_o    (word0),
    .word1_o    (word1),
    .two_words_o(two_words),
    .range_err_o(range_err)
  );

  assign accept    = cmd_valid && cmd_ready;
  assign err_range = err_q;

`ifdef INSTR_SEQ_ENC_SKID_EN
  // Entry 0 is the head; bit 16 of each entry is out_last.
  logic [16:0] ent_q [2];
  logic [16:0] ent_d [2];
  logic [1:0]  cnt_q, cnt_d, cnt_pop;
  logic        ready_q, ready_d;
  logic        pop, push;
  logic [16:0] push_word;

  assign out_valid = (cnt_q != 2'd0);
  assign out_instr = ent_q[0][15:0];
  assign out_last  = ent_q[0][16];
  assign cmd_ready = ready_q && !rst;

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    ent_d     = ent_q;
    err_d     = accept && range_err;
    push      = 1'b0;
    push_word = 17'h0;
    pop       = out_valid && out_ready;

    if (state_q == OUT_HI) begin
      if (cnt_q != 2'd2 || pop) begin
        push      = 1'b1;
        push_word = {1'b1, hi_q};
        state_d   = OUT;
      end
    end else if (accept && !range_err) begin
      push      = 1'b1;
      push_word = {!two_words, word0};
      hi_d      = word1;
      state_d   = two_words ? OUT_HI : OUT;
    end

    cnt_pop = cnt_q - {1'b0, pop};
    if (pop) ent_d[0] = ent_q[1];
    if (push) begin
      if (cnt_pop == 2'd0) ent_d[0] = push_word;
      else                 ent_d[1] = push_word;
    end
    cnt_d = cnt_pop + {1'b0, push};

    if (state_d != OUT_HI) state_d = (cnt_d == 2'd0) ? IDLE : OUT;
    // Ready only while the second slot is free, so an accept never overflows.
    ready_d = (cnt_d <= 2'd1) && (state_d != OUT_HI);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hi_q     <= 16'h0;
      err_q    <= 1'b0;
      cnt_q    <= 2'd0;
      ready_q  <= 1'b0;
      ent_q[0] <= 17'h0;
      ent_q[1] <= 17'h0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
    end
  end
`else
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_instr_q, out_instr_d;
  logic        out_last_q, out_last_d;
  logic        out_hs;

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_last  = out_last_q;
  assign out_hs    = out_valid_q && out_ready;
  assign cmd_ready = !rst && (state_q != OUT_HI) && (!out_valid_q || out_ready);

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_last_d  = out_last_q;
    err_d       = 1'b0;

    case (state_q)
      OUT_HI: begin
        if (out_hs) begin
          out_instr_d = hi_q;
          out_last_d  = 1'b1;
          state_d     = OUT;
        end
      end
      default: begin
        if (out_hs) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
        if (accept && range_err) begin
          err_d = 1'b1;
        end else if (accept) begin
          out_valid_d = 1'b1;
          out_instr_d = word0;
          out_last_d  = !two_words;
          hi_d        = word1;
          state_d     = two_words ? OUT_HI : OUT;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hi_q        <= 16'h0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_instr_q <= 16'h0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_last_q  <= out_last_d;
    end
  end
`endif

endmodule
